// File: rtl/izneuron_pop_param.sv
// Time-multiplexed Izhikevich neuron population. One shared fixed-point datapath
// walks N neurons held in register arrays: two cycles per neuron (READ, WRITE),
// preceded by an N-cycle initialisation sweep after reset.
module izneuron_pop_param #(
    parameter int unsigned N         = 128,
    parameter int unsigned W         = 32,
    parameter int unsigned FRAC      = 10,
    parameter int          A         = 82,
    parameter int          B         = 205,
    parameter int          C         = -66560,
    parameter int          D         = 2048,
    parameter int          V_INIT    = -66560,
    parameter int          U_INIT    = -13312,
    parameter int          VMAX      = 102400,
    parameter int unsigned HIST      = 16,
    parameter int unsigned DELAY_TAP = 14,
    localparam int unsigned LN       = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset_bar,
    input  logic          en,
    input  logic [W-1:0]  I_in,
    output logic [LN-1:0] I_idx,
    input  logic [W-1:0]  th_scaled,
    input  logic [LN-1:0] mon_idx,
    output logic [W-1:0]  v_mon,
    output logic          spike_mon,
    output logic [N-1:0]  population,
    output logic [LN:0]   spike_count,
    output logic          sweep_done,
    output logic          busy_init
);

    localparam int unsigned W2 = 2 * W;

    localparam logic signed [W-1:0]  AW     = W'(A);
    localparam logic signed [W-1:0]  BW     = W'(B);
    localparam logic signed [W-1:0]  CW     = W'(C);
    localparam logic signed [W-1:0]  DW     = W'(D);
    localparam logic signed [W-1:0]  VINITW = W'(V_INIT);
    localparam logic signed [W-1:0]  UINITW = W'(U_INIT);
    localparam logic signed [W-1:0]  VMAXW  = W'(VMAX);
    localparam logic signed [W-1:0]  K140   = W'(140) <<< FRAC;
    localparam logic signed [W2-1:0] K41    = W2'(41);
    localparam logic [LN-1:0]        LAST   = LN'(N - 1);

    typedef enum logic [1:0] {StInit, StRead, StWrite} state_e;

    state_e state_q, state_d;

    logic [LN-1:0]        idx_q;
    logic signed [W-1:0]  v_lat_q, u_lat_q, i_lat_q;
    logic [HIST-1:0]      h_lat_q;
    logic [N-1:0]         pop_sh_q, population_q;
    logic [LN:0]          cnt_sh_q, spike_count_q;
    logic                 sweep_done_q;
    logic signed [W-1:0]  v_mon_q;
    logic                 spike_mon_q;

    logic signed [W-1:0]  v_mem [N];
    logic signed [W-1:0]  u_mem [N];
    logic [HIST-1:0]      h_mem [N];

    // Datapath intermediates
    logic signed [W2-1:0] vsq, qp, bv, up;
    logic signed [W-1:0]  vv, q, v5, vprime, vn, vnext, bvs, uprime, unext;
    logic signed [W-1:0]  v_wr, u_wr;
    logic [HIST-1:0]      h_wr;
    logic                 fired;
    logic [N-1:0]         pop_bit;
    logic [LN:0]          cnt_inc;

    // State register
    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            state_q <= StInit;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; en only gates the start of a neuron
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StInit:  if (idx_q == LAST) state_d = StRead;
            StRead:  if (en) state_d = StWrite;
            StWrite: state_d = StRead;
            default: state_d = StInit;
        endcase
    end

    // Outputs decoded from state and registers
    always_comb begin
        busy_init   = (state_q == StInit);
        I_idx       = idx_q;
        v_mon       = v_mon_q;
        spike_mon   = spike_mon_q;
        population  = population_q;
        spike_count = spike_count_q;
        sweep_done  = sweep_done_q;
    end

    // Izhikevich update on the latched neuron; fired uses the pre-update v
    always_comb begin
        vsq    = W2'(v_lat_q) * W2'(v_lat_q);
        vv     = W'(vsq >>> FRAC);
        qp     = W2'(vv) * K41;
        q      = W'(qp >>> FRAC);
        v5     = (v_lat_q <<< 2) + v_lat_q;
        vprime = q + v5 + K140 - u_lat_q + i_lat_q;
        vn     = v_lat_q + vprime;
        vnext  = (vn > VMAXW) ? VMAXW : vn;
        bv     = W2'(BW) * W2'(v_lat_q);
        bvs    = W'(bv >>> FRAC) - u_lat_q;
        up     = W2'(bvs) * W2'(AW);
        uprime = W'(up >>> (FRAC + 2));
        unext  = u_lat_q + uprime;
        fired  = (v_lat_q > $signed(th_scaled));
        v_wr   = fired ? CW : vnext;
        u_wr   = fired ? (u_lat_q + DW) : unext;
        h_wr   = HIST'({h_lat_q, fired});
        pop_bit        = '0;
        pop_bit[idx_q] = fired;
        cnt_inc        = {{LN{1'b0}}, fired};
    end

    // Neuron state arrays: initialised by the INIT sweep, never reset directly
    always_ff @(posedge clk) begin
        if (state_q == StInit) begin
            v_mem[idx_q] <= VINITW;
            u_mem[idx_q] <= UINITW;
            h_mem[idx_q] <= '0;
        end else if (state_q == StWrite) begin
            v_mem[idx_q] <= v_wr;
            u_mem[idx_q] <= u_wr;
            h_mem[idx_q] <= h_wr;
        end
    end

    // Sequencing, operand latches, monitor and per-sweep accumulation
    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            idx_q         <= '0;
            v_lat_q       <= '0;
            u_lat_q       <= '0;
            i_lat_q       <= '0;
            h_lat_q       <= '0;
            pop_sh_q      <= '0;
            cnt_sh_q      <= '0;
            population_q  <= '0;
            spike_count_q <= '0;
            sweep_done_q  <= 1'b0;
            v_mon_q       <= '0;
            spike_mon_q   <= 1'b0;
        end else begin
            sweep_done_q <= 1'b0;
            case (state_q)
                StInit: begin
                    idx_q <= idx_q + LN'(1);
                end
                StRead: begin
                    if (en) begin
                        v_lat_q <= v_mem[idx_q];
                        u_lat_q <= u_mem[idx_q];
                        h_lat_q <= h_mem[idx_q];
                        i_lat_q <= $signed(I_in);
                    end
                end
                StWrite: begin
                    idx_q <= idx_q + LN'(1);
                    if (idx_q == mon_idx) begin
                        v_mon_q     <= v_wr;
                        spike_mon_q <= h_lat_q[DELAY_TAP];
                    end
                    if (idx_q == LAST) begin
                        population_q  <= pop_sh_q | pop_bit;
                        spike_count_q <= cnt_sh_q + cnt_inc;
                        pop_sh_q      <= '0;
                        cnt_sh_q      <= '0;
                        sweep_done_q  <= 1'b1;
                    end else begin
                        pop_sh_q <= pop_sh_q | pop_bit;
                        cnt_sh_q <= cnt_sh_q + cnt_inc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_izneuron_pop_param.sv
// Directed bench for izneuron_pop_param with a 16-neuron population.
module tb_izneuron_pop_param;

    localparam int N  = 16;
    localparam int LN = 4;
    localparam int W  = 32;

    localparam logic [W-1:0] TH_HI  = 32'h7FFF_FFFF;
    localparam logic [W-1:0] TH_30  = 32'd30720;
    localparam logic [W-1:0] TH_M70 = -32'sd71680;
    localparam logic [W-1:0] I_200  = 32'd204800;

    logic          clk;
    logic          reset_bar;
    logic          en;
    logic [W-1:0]  I_in;
    logic [LN-1:0] I_idx;
    logic [W-1:0]  th_scaled;
    logic [LN-1:0] mon_idx;
    logic [W-1:0]  v_mon;
    logic          spike_mon;
    logic [N-1:0]  population;
    logic [LN:0]   spike_count;
    logic          sweep_done;
    logic          busy_init;

    logic         en_base, en_rand, en_rnd;
    logic         i_alt;
    logic [W-1:0] i_const;

    int total = 0;
    int bad   = 0;
    int cyc;

    assign en   = en_rand ? en_rnd : en_base;
    // Odd neurons get the strong current in alternating mode
    assign I_in = i_alt ? (I_idx[0] ? I_200 : '0) : i_const;

    izneuron_pop_param #(.N(N)) dut (
        .clk        (clk),
        .reset_bar  (reset_bar),
        .en         (en),
        .I_in       (I_in),
        .I_idx      (I_idx),
        .th_scaled  (th_scaled),
        .mon_idx    (mon_idx),
        .v_mon      (v_mon),
        .spike_mon  (spike_mon),
        .population (population),
        .spike_count(spike_count),
        .sweep_done (sweep_done),
        .busy_init  (busy_init)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        en_rnd = 1'b1;
        forever begin
            @(negedge clk);
            en_rnd = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset_bar = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_bar = 1'b1;
    endtask

    task automatic wait_init(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (busy_init && n < 4 * N);
    endtask

    task automatic wait_sweep(input string tag, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!sweep_done && n < 20 * N);
        if (!sweep_done) chk({tag, "_timeout"}, sweep_done, 1);
    endtask

    initial begin
        reset_bar = 1'b0;
        en_base   = 1'b1;
        en_rand   = 1'b0;
        i_alt     = 1'b0;
        i_const   = '0;
        th_scaled = TH_30;
        mon_idx   = '0;

        // Reset values, init length, first-sweep latency, sub-threshold update
        do_reset();
        wait_init(cyc);
        chk("init_cycles", cyc, N);
        wait_sweep("t1", cyc);
        chk("sweep_cycles", cyc, 2 * N);
        chk("t1_count", spike_count, 0);
        chk("t1_pop", population, 0);
        chk("t1_vmon", $signed(v_mon), -69463);

        // Threshold below V_INIT: all fire, then u carries +d into the next sweep
        th_scaled = TH_M70;
        do_reset();
        wait_init(cyc);
        wait_sweep("t2a", cyc);
        chk("t2_pop_all", population, 16'hFFFF);
        chk("t2_count_all", spike_count, N);
        chk("t2_vmon_c", $signed(v_mon), -66560);
        th_scaled = TH_HI;
        wait_sweep("t2b", cyc);
        chk("t2_vmon_u", $signed(v_mon), -71511);
        chk("t2_pop_none", population, 0);
        chk("t2_count_none", spike_count, 0);

        // Strong drive clamps at VMAX, then everybody fires from the ceiling
        i_const = I_200;
        do_reset();
        wait_init(cyc);
        wait_sweep("t3a", cyc);
        chk("t3_vmon_clamp", $signed(v_mon), 102400);
        th_scaled = TH_30;
        wait_sweep("t3b", cyc);
        chk("t3_vmon_fire", $signed(v_mon), -66560);
        chk("t3_pop", population, 16'hFFFF);
        chk("t3_count", spike_count, N);

        // Single firing sweep shows on the delay tap exactly 15 sweeps later
        i_const   = '0;
        th_scaled = TH_M70;
        mon_idx   = 4'd5;
        do_reset();
        wait_init(cyc);
        for (int s = 1; s <= 18; s++) begin
            wait_sweep("t4", cyc);
            chk($sformatf("t4_spike_mon_s%0d", s), spike_mon, (s == 16) ? 1 : 0);
            if (s == 1) th_scaled = TH_HI;
        end

        // Per-neuron current via I_idx with random run-enable gaps
        i_alt     = 1'b1;
        th_scaled = TH_HI;
        mon_idx   = 4'd3;
        en_rand   = 1'b1;
        do_reset();
        wait_init(cyc);
        chk("t5_init_cycles", cyc, N);
        wait_sweep("t5a", cyc);
        chk("t5_vmon_odd", $signed(v_mon), 102400);
        chk("t5_pop_none", population, 0);
        th_scaled = TH_30;
        wait_sweep("t5b", cyc);
        chk("t5_pop_odd", population, 16'hAAAA);
        chk("t5_count_odd", spike_count, 8);
        chk("t5_vmon_fire", $signed(v_mon), -66560);
        en_rand = 1'b0;

        // Mid-sweep reset during WRITE of neuron N/2, then a clean restart
        i_alt     = 1'b0;
        th_scaled = TH_M70;
        mon_idx   = '0;
        do_reset();
        wait_init(cyc);
        wait_sweep("t6a", cyc);
        chk("t6_pre_pop", population, 16'hFFFF);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (I_idx != LN'(N / 2) && cyc < 4 * N);
        chk("t6_reach_mid", I_idx, N / 2);
        @(posedge clk);
        #1;
        reset_bar = 1'b0;
        #1;
        chk("t6_rst_vmon", v_mon, 0);
        chk("t6_rst_pop", population, 0);
        chk("t6_rst_count", spike_count, 0);
        chk("t6_rst_busy", busy_init, 1);
        chk("t6_rst_idx", I_idx, 0);
        chk("t6_rst_done", sweep_done, 0);
        chk("t6_rst_spike", spike_mon, 0);
        th_scaled = TH_30;
        @(negedge clk);
        reset_bar = 1'b1;
        wait_init(cyc);
        chk("t6_init_cycles", cyc, N);
        wait_sweep("t6b", cyc);
        chk("t6_sweep_cycles", cyc, 2 * N);
        chk("t6_vmon", $signed(v_mon), -69463);
        chk("t6_pop", population, 0);
        chk("t6_count", spike_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/izneuron_pop_param.md
Name: izneuron_pop_param

Overview:
- Parametrised, time-multiplexed Izhikevich neuron population; successor to the fixed 128-neuron, 32-bit engine.
- One shared datapath iterates over N neurons held in inferred register arrays (v, u, spike history).
- Adds: width/fraction/population-size generics, per-neuron current addressing, run-enable, init sweep, programmable spike-delay tap, per-sweep spike count, neuron monitor select.
- Sits between the spindle/afferent current source and downstream population/EMG consumers.

Parameters:
- N, 128, neurons in population (power of 2, ≥2); LN = log2(N).
- W, 32, datapath width (signed).
- FRAC, 10, fraction bits of v, u, I, c, d, thresholds (scale 1024).
- A, 82, a in Q(FRAC+2) (0.02·4096).
- B, 205, b in Q(FRAC) (0.2).
- C, -66560, reset potential c (-65 mV).
- D, 2048, recovery increment d (2).
- V_INIT, -66560, initial v. U_INIT, -13312, initial u.
- VMAX, 102400, v clamp ceiling (+100 mV).
- HIST, 16, spike-history bits per neuron. DELAY_TAP, 14, delayed-spike tap (< HIST).

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset_bar  in  1  asynchronous, active-low reset.
- en  in  1  run enable; sampled only at neuron boundary.
- I_in  in  W  signed current of neuron I_idx, sampled in READ.
- I_idx  out  LN  index of neuron whose current is requested.
- th_scaled  in  W  signed spike threshold (shared).
- mon_idx  in  LN  neuron selected for monitor outputs.
- v_mon  out  W  post-update v of mon_idx neuron.
- spike_mon  out  1  delayed spike (history[DELAY_TAP]) of mon_idx neuron.
- population  out  N  fired bits of last completed sweep, bit k = neuron k.
- spike_count  out  LN+1  number of fired neurons in last sweep.
- sweep_done  out  1  one-cycle strobe on sweep completion.
- busy_init  out  1  high during init sweep.

Behaviour:
- Reset (reset_bar=0, async): state INIT, idx=0, v_mon=0, spike_mon=0, population=0, spike_count=0, sweep_done=0, busy_init=1, I_idx=0. Arrays not reset directly.
- INIT: one neuron per cycle, writes v=V_INIT, u=U_INIT, hist=0; after idx N-1 → idx=0, busy_init=0, state READ. Duration exactly N cycles.
- READ: if en=0 stay, nothing changes. Else latch v[idx], u[idx], hist[idx], I_in → WRITE. I_idx = idx throughout READ.
- WRITE: compute, write back v, u, hist; accumulate fired into population shadow and counter; idx wraps mod N; → READ. 2 cycles per neuron, 2N per sweep.
- Datapath (signed, full 2W products, Q-realign = arithmetic shift right, floor):
  - vv = (v·v)>>>FRAC; q = (vv·41)>>>FRAC; v5 = (v<<<2)+v.
  - vprime = q + v5 + (140<<FRAC) − u + I; vn = v + vprime (W-bit wrap).
  - vnext = VMAX if vn > VMAX else vn.
  - uprime = (((B·v)>>>FRAC) − u)·A >>> (FRAC+2); unext = u + uprime.
  - fired = (v > th_scaled), strictly greater; uses latched pre-update v.
  - fired: v←C, u←u+D; else v←vnext, u←unext.
  - hist ← {hist[HIST-2:0], fired}.
- Monitor: in WRITE with idx==mon_idx, v_mon←written v, spike_mon←latched hist[DELAY_TAP]. Tap reflects fired status DELAY_TAP+1 sweeps earlier.
- Sweep end (WRITE of idx N-1): the next cycle population/spike_count take sweep values (incl. neuron N-1), sweep_done=1 for exactly that cycle, shadow/counter clear.
- en deasserted mid-neuron: current WRITE completes, then hold in READ. No partial updates.
- mon_idx/th_scaled changes take effect on the next READ/WRITE using them. No glitch requirements.
- reset_bar low at any point aborts the sweep and restarts INIT. No partial state survives.

Test Plan:
- Reset then en=1, th=30·1024, I=0: busy_init high exactly N cycles; first sweep_done 2N cycles after busy_init falls; spike_count=0; population=0.
- th=-70·1024 (below V_INIT), I=0: first sweep population=all ones, spike_count=N, v_mon=-66560. Next sweep u of mon neuron = -13312+2048 = -11264, visible via golden-model match of v_mon.
- I_in=200·1024 for all, th=0x7FFFFFFF: v_mon=102400 (clamped) after first sweep. Then th=30·1024: next sweep all fire, v_mon=-66560.
- th low for exactly one sweep, then high; mon_idx=5: spike_mon=1 for exactly one sweep, DELAY_TAP+1 sweeps after the firing sweep.
- Random per-neuron I_in driven by I_idx, random th: v_mon, population, spike_count bit-exact vs fixed-point reference model over 50 sweeps. Toggle en randomly: result unchanged except timing.
- reset_bar pulsed mid-sweep (idx=N/2, WRITE phase): outputs zero immediately, INIT restarts, subsequent trace identical to fresh-reset run.
